// File: rtl/gauss_ctrl_pkg.sv
// rtl/gauss_ctrl_pkg.sv - shared types and defaults for the Gaussian pipeline controller
//   state_e        : controller FSM states
//   CNT_W          : default width of all internal counters
//   PRIME_CNT_DEF  : default pipeline warm-up depth in pixels
//   FRAME_PIX_DEF  : default source pixels per frame
package gauss_ctrl_pkg;

  localparam int CNT_W         = 15;
  localparam int PRIME_CNT_DEF = 1612;
  localparam int FRAME_PIX_DEF = 19200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/gauss_pipe_ctrl.sv
// rtl/gauss_pipe_ctrl.sv - frame sequencer for a two-stage Gaussian pipeline
//   clk, rst       : clock and synchronous active-high reset
//   start          : single-cycle frame start request (honoured in IDLE only)
//   src_valid      : FWFT source has a pixel this cycle
//   src_rd_en      : pop the source pixel this cycle
//   pipe_en        : clock enable for both Gaussian stages
//   pipe_zero      : feed a zero pixel into the first stage (flush)
//   fifo_wr_en     : write the second-stage output to the output FIFO
//   fifo_full      : output FIFO full
//   busy           : high in every state except IDLE
//   done           : one-cycle pulse at frame completion
module gauss_pipe_ctrl
  import gauss_ctrl_pkg::*;
#(
  parameter int PRIME_CNT = PRIME_CNT_DEF,
  parameter int FRAME_PIX = FRAME_PIX_DEF,
  parameter int CNT_W     = gauss_ctrl_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic src_valid,
  output logic src_rd_en,
  output logic pipe_en,
  output logic pipe_zero,
  output logic fifo_wr_en,
  input  logic fifo_full,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CNT - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;
  logic             adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
    end
  end

  // Every output is a pure function of state and the current inputs so a
  // stall (no src_valid, or fifo_full) freezes pop, shift and write in the
  // same cycle. Counters only move on adv, so each stops at its terminal
  // value when the state leaves the phase that counts it.
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    fl_cnt_d   = fl_cnt_q;
    adv        = 1'b0;
    src_rd_en  = 1'b0;
    pipe_en    = 1'b0;
    pipe_zero  = 1'b0;
    fifo_wr_en = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PRIME;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          fl_cnt_d  = '0;
        end
      end
      // Warm-up: stage outputs are not yet meaningful, so the FIFO is never
      // written and fifo_full is irrelevant.
      ST_PRIME: begin
        adv       = src_valid;
        src_rd_en = adv;
        if (adv) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == PRIME_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        adv        = src_valid & ~fifo_full;
        src_rd_en  = adv;
        fifo_wr_en = adv;
        if (adv) begin
          in_cnt_d  = in_cnt_q + 1'b1;
          out_cnt_d = out_cnt_q + 1'b1;
          if (in_cnt_q == FRAME_LAST) state_d = ST_FLUSH;
        end
      end
      // Push zeros to drain the PRIME_CNT pixels still inside the pipeline.
      ST_FLUSH: begin
        pipe_zero  = 1'b1;
        adv        = ~fifo_full;
        fifo_wr_en = adv;
        if (adv) begin
          out_cnt_d = out_cnt_q + 1'b1;
          fl_cnt_d  = fl_cnt_q + 1'b1;
          if (fl_cnt_q == PRIME_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    pipe_en = adv;
  end

endmodule

// File: tb/tb_gauss_pipe_ctrl.sv
// tb/tb_gauss_pipe_ctrl.sv - directed self-checking bench for gauss_pipe_ctrl
module tb_gauss_pipe_ctrl;

  localparam int P = 4;
  localparam int F = 10;

  logic clk = 1'b0;
  logic rst, start, src_valid, fifo_full;
  logic src_rd_en, pipe_en, pipe_zero, fifo_wr_en, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  int writes  = 0;
  int dones   = 0;

  always #5 clk = ~clk;

  gauss_pipe_ctrl #(
    .PRIME_CNT (P),
    .FRAME_PIX (F),
    .CNT_W     (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_valid  (src_valid),
    .src_rd_en  (src_rd_en),
    .pipe_en    (pipe_en),
    .pipe_zero  (pipe_zero),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .done       (done)
  );

  // Inputs only change 1 ns after a rising edge, so the falling edge sees
  // the values that the next rising edge will act on.
  always @(negedge clk) begin
    if (src_rd_en)  pops   <= pops + 1;
    if (fifo_wr_en) writes <= writes + 1;
    if (done)       dones  <= dones + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {busy, done, src_rd_en, pipe_en, pipe_zero, fifo_wr_en}
  function automatic int outs();
    return int'({busy, done, src_rd_en, pipe_en, pipe_zero, fifo_wr_en});
  endfunction

  // Nominal frame, k = cycle index with start at k = 0.
  function automatic int exp_nominal(input int k);
    if (k >= 1 && k <= 4)   return int'(6'b101100);
    if (k >= 5 && k <= 10)  return int'(6'b101101);
    if (k >= 11 && k <= 14) return int'(6'b100111);
    if (k == 15)            return int'(6'b110000);
    return 0;
  endfunction

  int p0, w0, d0, dk, viol;

  initial begin
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; fifo_full = 1'b0;
    step();
    step();
    #1;
    check("reset_outs", outs(), 0);
    rst = 1'b0;
    src_valid = 1'b1;
    step();
    #1;
    check("idle_ignores_src_valid", outs(), 0);

    // 1: nominal frame, constant src_valid, no backpressure
    p0 = pops; w0 = writes; d0 = dones;
    for (int k = 0; k <= 17; k++) begin
      step();
      start = (k == 0); src_valid = 1'b1; fifo_full = 1'b0;
      #1;
      check($sformatf("nominal_k%0d", k), outs(), exp_nominal(k));
    end
    start = 1'b0;
    step();
    check("nominal_pops", pops - p0, F);
    check("nominal_writes", writes - w0, F);
    check("nominal_dones", dones - d0, 1);

    // 2: src_valid toggling every cycle
    p0 = pops; w0 = writes; d0 = dones; viol = 0;
    for (int k = 0; k <= 40; k++) begin
      step();
      start = (k == 0); src_valid = (k % 2 == 1); fifo_full = 1'b0;
      #1;
      if (!src_valid && busy && !pipe_zero && pipe_en) viol++;
    end
    start = 1'b0; src_valid = 1'b1;
    step();
    check("toggle_gate_viol", viol, 0);
    check("toggle_pops", pops - p0, F);
    check("toggle_writes", writes - w0, F);
    check("toggle_idle_at_end", int'(busy), 0);

    // 3: fifo_full for 3 cycles at the 2nd RUN pixel (k = 6..8)
    p0 = pops; w0 = writes; dk = -1;
    for (int k = 0; k <= 22; k++) begin
      step();
      start = (k == 0); src_valid = 1'b1; fifo_full = (k >= 6 && k <= 8);
      #1;
      if (fifo_full)
        check($sformatf("run_stall_k%0d", k), int'({src_rd_en, pipe_en, fifo_wr_en}), 0);
      if (k == 9) begin
        check("run_stall_pops_held", pops - p0, 5);
        check("run_stall_writes_held", writes - w0, 1);
        check("run_stall_resume", outs(), int'(6'b101101));
      end
      if (done && dk < 0) dk = k;
    end
    start = 1'b0; fifo_full = 1'b0;
    step();
    check("run_stall_done_k", dk, 18);
    check("run_stall_pops", pops - p0, F);
    check("run_stall_writes", writes - w0, F);

    // 4: fifo_full for 2 cycles inside FLUSH (k = 12, 13)
    w0 = writes; dk = -1;
    for (int k = 0; k <= 22; k++) begin
      step();
      start = (k == 0); src_valid = 1'b1; fifo_full = (k == 12 || k == 13);
      #1;
      if (fifo_full)
        check($sformatf("flush_stall_k%0d", k), int'({pipe_en, fifo_wr_en, pipe_zero}), 1);
      if (done && dk < 0) dk = k;
    end
    start = 1'b0; fifo_full = 1'b0;
    step();
    check("flush_stall_done_k", dk, 17);
    check("flush_stall_writes", writes - w0, F);

    // 5: reset at the 3rd RUN pixel (k = 7), then a clean frame
    for (int k = 0; k <= 10; k++) begin
      step();
      start = (k == 0); src_valid = 1'b1; rst = (k == 7);
      #1;
      if (k == 8) check("midframe_rst_outs", outs(), 0);
    end
    rst = 1'b0;
    p0 = pops; w0 = writes; dk = -1;
    for (int k = 0; k <= 18; k++) begin
      step();
      start = (k == 0); src_valid = 1'b1;
      #1;
      if (done && dk < 0) dk = k;
    end
    start = 1'b0;
    step();
    check("after_rst_done_k", dk, 15);
    check("after_rst_pops", pops - p0, F);
    check("after_rst_writes", writes - w0, F);

    // 6: start pulsed during PRIME (k = 2) and DONE (k = 15)
    d0 = dones; dk = -1;
    for (int k = 0; k <= 24; k++) begin
      step();
      start = (k == 0 || k == 2 || k == 15); src_valid = 1'b1;
      #1;
      if (done && dk < 0) dk = k;
      if (k == 16) check("start_in_done_idle_k16", int'(busy), 0);
      if (k == 22) check("start_in_done_idle_k22", int'(busy), 0);
    end
    start = 1'b0;
    step();
    check("extra_start_done_k", dk, 15);
    check("extra_start_dones", dones - d0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
